// File: rtl/twiddle_mult.sv
// -----------------------------------------------------------------------------
// twiddle_mult
//
// Three-stage pipelined complex multiplier placed between the BF2II output of
// one R2^2SDF FFT stage and the BF2I input of the next. Each accepted sample is
// multiplied by the twiddle factor that the CORDIC generator has already
// aligned to it. The twiddle is in Q1.15, so +1.0 is 32768. The result is
// rounded half-up and saturated to data_bw+1 bits.
//
// Samples that arrive while the twiddle stream is not ready are discarded and
// counted in a saturating drop counter. There is no backpressure, so the
// downstream stage must take every dout_valid cycle.
//
// Ports
//   sys_clk             clock, all state on the rising edge
//   sys_nrst            asynchronous active-low reset
//   sys_en              global clock enable; low freezes every register
//   din_r, din_i        signed input sample (data_bw)
//   din_valid           input sample present this cycle
//   tw_fac_r, tw_fac_i  signed Q1.15 twiddle (tw_bw), aligned to din
//   tw_rdy              twiddle stream valid (generator cordic_rdy)
//   dout_r, dout_i      signed rounded/saturated product (data_bw+1)
//   dout_valid          product valid
//   drop_cnt            saturating count of rejected samples (cnt_bw)
//   busy                any pipeline stage holds a valid sample
//
// Pipeline
//   stage 1 : register operands on accept           (v1)
//   stage 2 : four partial products                 (v2)
//   stage 3 : add/sub, round, saturate -> dout      (dout_valid)
// -----------------------------------------------------------------------------
module twiddle_mult #(
  parameter int data_bw = 16,
  parameter int tw_bw   = 17,
  parameter int cnt_bw  = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_nrst,
  input  logic                      sys_en,
  input  logic signed [data_bw-1:0] din_r,
  input  logic signed [data_bw-1:0] din_i,
  input  logic                      din_valid,
  input  logic signed [tw_bw-1:0]   tw_fac_r,
  input  logic signed [tw_bw-1:0]   tw_fac_i,
  input  logic                      tw_rdy,
  output logic signed [data_bw:0]   dout_r,
  output logic signed [data_bw:0]   dout_i,
  output logic                      dout_valid,
  output logic [cnt_bw-1:0]         drop_cnt,
  output logic                      busy
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int PROD_BW = data_bw + tw_bw;  // one partial product
  localparam int SUM_BW  = PROD_BW + 1;      // sum/difference of two products
  localparam int OUT_BW  = data_bw + 1;      // output component
  localparam int FRAC_BW = 15;               // Q1.15 twiddle fraction bits

  // Adding one half LSB before the arithmetic shift makes the rounding
  // half-up, so -1.5 becomes -1 and +1.5 becomes +2.
  localparam logic signed [SUM_BW-1:0] RND_HALF = SUM_BW'(2 ** (FRAC_BW - 1));
  localparam logic signed [SUM_BW-1:0] OUT_MAX  = SUM_BW'((2 ** data_bw) - 1);
  localparam logic signed [SUM_BW-1:0] OUT_MIN  = -(SUM_BW'(2 ** data_bw));

  localparam logic [cnt_bw-1:0] CNT_ONE = cnt_bw'(1);
  localparam logic [cnt_bw-1:0] CNT_MAX = '1;

  // Clip a rounded, shifted value into the output range.
  function automatic logic signed [OUT_BW-1:0] sat_out(
    input logic signed [SUM_BW-1:0] x
  );
    if (x > OUT_MAX) begin
      return OUT_MAX[OUT_BW-1:0];
    end else if (x < OUT_MIN) begin
      return OUT_MIN[OUT_BW-1:0];
    end else begin
      return x[OUT_BW-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic drop;

  // tw_rdy is sampled on the same edge as din_valid, so the cycle in which
  // tw_rdy rises already accepts its sample.
  assign accept = sys_en & din_valid &  tw_rdy;
  assign drop   = sys_en & din_valid & ~tw_rdy;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Stage 1: operands
  logic signed [data_bw-1:0] ar_q, ar_d;
  logic signed [data_bw-1:0] ai_q, ai_d;
  logic signed [tw_bw-1:0]   wr_q, wr_d;
  logic signed [tw_bw-1:0]   wi_q, wi_d;
  logic                      v1_q, v1_d;

  // Stage 2: partial products
  logic signed [PROD_BW-1:0] p_rr_q, p_rr_d;  // ar*wr
  logic signed [PROD_BW-1:0] p_ii_q, p_ii_d;  // ai*wi
  logic signed [PROD_BW-1:0] p_ri_q, p_ri_d;  // ar*wi
  logic signed [PROD_BW-1:0] p_ir_q, p_ir_d;  // ai*wr
  logic                      v2_q, v2_d;

  // Stage 3: result
  logic signed [OUT_BW-1:0]  dout_r_q, dout_r_d;
  logic signed [OUT_BW-1:0]  dout_i_q, dout_i_d;
  logic                      dout_valid_q, dout_valid_d;

  // Drop counter
  logic [cnt_bw-1:0]         drop_cnt_q, drop_cnt_d;

  // Stage 3 arithmetic intermediates
  logic signed [SUM_BW-1:0]  re_sum, im_sum;
  logic signed [SUM_BW-1:0]  re_rnd, im_rnd;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that skips
    // an assignment would otherwise infer a latch.
    ar_d         = ar_q;
    ai_d         = ai_q;
    wr_d         = wr_q;
    wi_d         = wi_q;
    v1_d         = v1_q;
    p_rr_d       = p_rr_q;
    p_ii_d       = p_ii_q;
    p_ri_d       = p_ri_q;
    p_ir_d       = p_ir_q;
    v2_d         = v2_q;
    dout_r_d     = dout_r_q;
    dout_i_d     = dout_i_q;
    dout_valid_d = dout_valid_q;
    drop_cnt_d   = drop_cnt_q;

    re_sum = SUM_BW'(p_rr_q) - SUM_BW'(p_ii_q);
    im_sum = SUM_BW'(p_ri_q) + SUM_BW'(p_ir_q);
    re_rnd = (re_sum + RND_HALF) >>> FRAC_BW;
    im_rnd = (im_sum + RND_HALF) >>> FRAC_BW;

    if (sys_en) begin
      // Stage 1: operands load only on accept and otherwise hold, so an idle
      // input does not toggle the multipliers.
      v1_d = accept;
      if (accept) begin
        ar_d = din_r;
        ai_d = din_i;
        wr_d = tw_fac_r;
        wi_d = tw_fac_i;
      end

      // Stage 2: the operands are sign-extended to the full product width
      // before multiplying.
      v2_d = v1_q;
      if (v1_q) begin
        p_rr_d = PROD_BW'(ar_q) * PROD_BW'(wr_q);
        p_ii_d = PROD_BW'(ai_q) * PROD_BW'(wi_q);
        p_ri_d = PROD_BW'(ar_q) * PROD_BW'(wi_q);
        p_ir_d = PROD_BW'(ai_q) * PROD_BW'(wr_q);
      end

      // Stage 3: dout changes only with a valid result and holds otherwise.
      dout_valid_d = v2_q;
      if (v2_q) begin
        dout_r_d = sat_out(re_rnd);
        dout_i_d = sat_out(im_rnd);
      end

      // The drop counter sticks at full scale rather than wrapping.
      if (drop && (drop_cnt_q != CNT_MAX)) begin
        drop_cnt_d = drop_cnt_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the valids. dout is
  // visible while dout_valid is low, so it must read 0 out of reset.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      ar_q         <= '0;
      ai_q         <= '0;
      wr_q         <= '0;
      wi_q         <= '0;
      v1_q         <= 1'b0;
      p_rr_q       <= '0;
      p_ii_q       <= '0;
      p_ri_q       <= '0;
      p_ir_q       <= '0;
      v2_q         <= 1'b0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
      dout_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage samples the values its
      // neighbours held before this edge.
      ar_q         <= ar_d;
      ai_q         <= ai_d;
      wr_q         <= wr_d;
      wi_q         <= wi_d;
      v1_q         <= v1_d;
      p_rr_q       <= p_rr_d;
      p_ii_q       <= p_ii_d;
      p_ri_q       <= p_ri_d;
      p_ir_q       <= p_ir_d;
      v2_q         <= v2_d;
      dout_r_q     <= dout_r_d;
      dout_i_q     <= dout_i_d;
      dout_valid_q <= dout_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout_r     = dout_r_q;
  assign dout_i     = dout_i_q;
  assign dout_valid = dout_valid_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = v1_q | v2_q | dout_valid_q;

endmodule

// File: doc/twiddle_mult.md
# twiddle_mult

Pipelined complex multiplier that consumes the twiddle-factor stream produced by the CORDIC twiddle generator and applies it to the butterfly output samples of an R2²SDF FFT stage. The multiplier sits between a stage's BF2II output and the next stage's BF2I input. It gates data acceptance on the generator's ready flag, multiplies the data by the twiddle in Q1.15 with round-half-up and saturation, and counts samples dropped while the twiddle stream was not ready.

## Interface
Parameters:
- data_bw, 16, width of signed input real/imag components
- tw_bw, 17, width of signed twiddle components, Q1.15 (+1.0 = 32768)
- cnt_bw, 16, width of the saturating drop counter

Ports:
- sys_clk  in  1  clock, all state on rising edge
- sys_nrst  in  1  reset, asynchronous, active-low
- sys_en  in  1  global clock enable; low freezes every register, including the drop counter
- din_r, din_i  in  data_bw  signed input sample
- din_valid  in  1  input sample present this cycle
- tw_fac_r, tw_fac_i  in  tw_bw  signed twiddle, already cycle-aligned to din by the generator
- tw_rdy  in  1  twiddle stream valid; driven by the generator's cordic_rdy
- dout_r, dout_i  out  data_bw+1  signed product
- dout_valid  out  1  product valid
- drop_cnt  out  cnt_bw  saturating count of rejected samples
- busy  out  1  high while any pipeline stage holds a valid sample

## Operation
- Accept condition: sys_en & din_valid & tw_rdy. On accept, stage 1 registers din and the twiddle, and v1 is set to 1. With sys_en high and no accept, v1 is set to 0 and the data registers hold.
- Drop condition: sys_en & din_valid & !tw_rdy. The sample is discarded and drop_cnt increments, saturating at 2^cnt_bw−1.
- Stage 2 forms four signed products, each data_bw+tw_bw bits: ar·wr, ai·wi, ar·wi, ai·wr. v2 <= v1.
- Stage 3 arithmetic:
  - re = ar·wr − ai·wi and im = ar·wi + ai·wr, each data_bw+tw_bw+1 bits.
  - Rounding: add 2^14, then arithmetic shift right by 15.
  - Saturation: clip to [−2^data_bw, 2^data_bw−1].
  - Register the result to dout; dout_valid <= v2.
- dout holds its last value while dout_valid is 0. No bubble squeezing is performed.
- busy = v1 | v2 | dout_valid.
- No backpressure. The downstream stage must accept every dout_valid cycle.

## Timing
- Reset values: dout_r = 0, dout_i = 0, dout_valid = 0, drop_cnt = 0, busy = 0, and all internal valids = 0.
- Latency: 3 enabled clock edges from the accept edge to dout_valid high. Throughput is 1 sample per enabled cycle.
- sys_en low for N cycles stretches latency by exactly N. The pipeline contents and drop_cnt are preserved.
- tw_rdy is sampled on the same edge as din_valid. A tw_rdy rising edge makes that same cycle's sample acceptable.
- tw_rdy falling mid-stream: samples already in the pipeline complete normally. New samples are dropped and counted.
- drop_cnt at its maximum with another drop: the counter holds at its maximum and does not wrap.
- Reset asserted mid-operation: all valids and outputs clear immediately and asynchronously. No partial result appears after release. The first output after release needs a fresh accept followed by 3 edges.
- din_valid high with sys_en low: the sample is neither accepted nor counted.

## Test plan
- Reset check: assert sys_nrst low while driving random inputs -> all outputs 0. After release, with din_valid = 0, dout_valid stays 0 and busy stays 0.
- Identity twiddle: tw = (32768, 0), din = (1000, −2000), tw_rdy = 1 -> dout = (1000, −2000) with dout_valid on the 3rd edge. Multiplying by j instead, tw = (0, 32768) -> dout = (2000, 1000).
- Rounding:
  - din = (1, 0), tw = (16384, 0) -> dout = (1, 0).
  - din = (−1, 0), same tw -> dout = (0, 0).
- Saturation: din = (−32768, −32768), tw = (−32768, 32768) -> dout = (65535, 0).
- Drop and ready: tw_rdy = 0 with din_valid = 1 for 5 cycles -> drop_cnt = 5 and no dout_valid. Then raise tw_rdy with 8 back-to-back samples -> exactly 8 dout_valid cycles, contiguous and in order. Separately, preload drop_cnt to 2^cnt_bw−1 and force 2 more drops -> drop_cnt stays at its maximum.
- Enable and reset mid-stream:
  - Drop sys_en for 4 cycles with 2 samples in flight -> outputs appear 4 cycles late, with values unchanged.
  - Pulse sys_nrst low with 3 samples in flight -> no dout_valid until a new accept plus 3 edges.
